// File: rtl/reset_sequencer.sv
// reset_sequencer: releases the CPU-domain reset once PLL lock has been stable and a hold window has elapsed.
// Optional feature macro RST_SEQ_LOSS_COUNT_EN builds the saturating loss_count counter; otherwise it reads 0.
module reset_sequencer #(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int HOLD_CYCLES        = 16,
    parameter int CNT_W              = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pll_locked,
    input  logic             soft_rst_req,
    output logic             cpu_rst,
    output logic             ready,
    output logic             lock_lost,
    output logic [CNT_W-1:0] loss_count
);

    localparam int CNT_MAX = (LOCK_STABLE_CYCLES > HOLD_CYCLES) ? LOCK_STABLE_CYCLES : HOLD_CYCLES;
    localparam int SEQ_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [SEQ_W-1:0] STABLE_LAST = SEQ_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [SEQ_W-1:0] HOLD_LAST   = SEQ_W'(HOLD_CYCLES - 1);
    localparam logic [SEQ_W-1:0] SEQ_ZERO    = SEQ_W'(0);
    localparam logic [SEQ_W-1:0] SEQ_ONE     = SEQ_W'(1);

    typedef enum logic [1:0] {
        S_WAIT_LOCK = 2'd0,
        S_STABLE    = 2'd1,
        S_HOLD      = 2'd2,
        S_RUN       = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_locked_s;
    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SEQ_W-1:0]       r_cnt;
    logic [SEQ_W-1:0]       w_cnt_nxt;
    logic                   w_loss_evt;
    logic                   r_cpu_rst;
    logic                   r_ready;
    logic                   r_lock_lost;

    // Lock synchronizer: pll_locked is asynchronous to clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {SYNC_STAGES{1'b0}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pll_locked};
        end
    end

    assign w_locked_s = r_sync[SYNC_STAGES-1];

    // Next-state and counter logic; lock loss takes priority over soft reset in every state.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_loss_evt  = 1'b0;
        case (r_state)
            S_WAIT_LOCK: begin
                if (w_locked_s) begin
                    w_state_nxt = S_STABLE;
                    w_cnt_nxt   = SEQ_ZERO;
                end else begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_cnt_nxt   = SEQ_ZERO;
                end
            end
            S_STABLE: begin
                if (!w_locked_s) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_cnt_nxt   = SEQ_ZERO;
                end else if (r_cnt == STABLE_LAST) begin
                    w_state_nxt = S_HOLD;
                    w_cnt_nxt   = SEQ_ZERO;
                end else begin
                    w_state_nxt = S_STABLE;
                    w_cnt_nxt   = r_cnt + SEQ_ONE;
                end
            end
            S_HOLD: begin
                if (!w_locked_s) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_cnt_nxt   = SEQ_ZERO;
                end else if (soft_rst_req) begin
                    // A held request keeps restarting the hold window.
                    w_state_nxt = S_HOLD;
                    w_cnt_nxt   = SEQ_ZERO;
                end else if (r_cnt == HOLD_LAST) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = SEQ_ZERO;
                end else begin
                    w_state_nxt = S_HOLD;
                    w_cnt_nxt   = r_cnt + SEQ_ONE;
                end
            end
            S_RUN: begin
                if (!w_locked_s) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_cnt_nxt   = SEQ_ZERO;
                    w_loss_evt  = 1'b1;
                end else if (soft_rst_req) begin
                    w_state_nxt = S_HOLD;
                    w_cnt_nxt   = SEQ_ZERO;
                end else begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = r_cnt;
                end
            end
            default: begin
                w_state_nxt = S_WAIT_LOCK;
                w_cnt_nxt   = SEQ_ZERO;
            end
        endcase
    end

    // State register; reset outputs are registered from next state so they never glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_WAIT_LOCK;
            r_cnt       <= SEQ_ZERO;
            r_cpu_rst   <= 1'b1;
            r_ready     <= 1'b0;
            r_lock_lost <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_cpu_rst <= (w_state_nxt != S_RUN);
            r_ready   <= (w_state_nxt == S_RUN);
            if (w_loss_evt) begin
                r_lock_lost <= 1'b1;
            end else begin
                r_lock_lost <= r_lock_lost;
            end
        end
    end

    assign cpu_rst   = r_cpu_rst;
    assign ready     = r_ready;
    assign lock_lost = r_lock_lost;

`ifdef RST_SEQ_LOSS_COUNT_EN
    logic [CNT_W-1:0] r_loss_count;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        if (value == {CNT_W{1'b1}}) begin
            sat_inc = value;
        end else begin
            sat_inc = value + CNT_W'(1);
        end
    endfunction

    // Saturating count of lock losses observed while running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_loss_count <= {CNT_W{1'b0}};
        end else if (w_loss_evt) begin
            r_loss_count <= sat_inc(r_loss_count);
        end else begin
            r_loss_count <= r_loss_count;
        end
    end

    assign loss_count = r_loss_count;
`else
    assign loss_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed testbench for reset_sequencer with small parameters (2/8/4/2).
module tb_reset_sequencer;

    localparam int SYNC_STAGES = 2;
    localparam int LSC         = 8;
    localparam int HC          = 4;
    localparam int CNT_W       = 2;
    // Edges from lock rise (before edge 1) until cpu_rst falls.
    localparam int RELEASE_EDGES = SYNC_STAGES + 1 + LSC + HC;

`ifdef RST_SEQ_LOSS_COUNT_EN
    localparam bit LC_EN = 1'b1;
`else
    localparam bit LC_EN = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             pll_locked;
    logic             soft_rst_req;
    logic             cpu_rst;
    logic             ready;
    logic             lock_lost;
    logic [CNT_W-1:0] loss_count;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_loss;

    reset_sequencer #(
        .SYNC_STAGES        (SYNC_STAGES),
        .LOCK_STABLE_CYCLES (LSC),
        .HOLD_CYCLES        (HC),
        .CNT_W              (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pll_locked   (pll_locked),
        .soft_rst_req (soft_rst_req),
        .cpu_rst      (cpu_rst),
        .ready        (ready),
        .lock_lost    (lock_lost),
        .loss_count   (loss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // cpu_rst must stay high for n-1 edges and fall on the n-th edge.
    task automatic expect_release(input string tag, input int n);
        for (int i = 1; i < n; i++) begin
            cyc(1);
            chk({tag, "_rst_hi"}, 32'(cpu_rst), 32'd1);
        end
        cyc(1);
        chk({tag, "_rst_lo"}, 32'(cpu_rst), 32'd0);
        chk({tag, "_ready"}, 32'(ready), 32'd1);
    endtask

    initial begin
        rst_n        = 1'b0;
        pll_locked   = 1'b0;
        soft_rst_req = 1'b0;
        cyc(2);
        chk("reset_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("reset_ready", 32'(ready), 32'd0);
        chk("reset_lock_lost", 32'(lock_lost), 32'd0);
        chk("reset_loss_count", 32'(loss_count), 32'd0);

        // Power-up: lock rises before edge 1.
        rst_n      = 1'b1;
        pll_locked = 1'b1;
        expect_release("powerup", RELEASE_EDGES);

        // Soft reset pulse of one cycle.
        soft_rst_req = 1'b1;
        cyc(1);
        chk("soft_pulse_assert", 32'(cpu_rst), 32'd1);
        chk("soft_pulse_ready", 32'(ready), 32'd0);
        soft_rst_req = 1'b0;
        expect_release("soft_pulse", HC);

        // Soft reset held for 10 cycles.
        soft_rst_req = 1'b1;
        cyc(1);
        chk("soft_hold_assert", 32'(cpu_rst), 32'd1);
        cyc(9);
        chk("soft_hold_still", 32'(cpu_rst), 32'd1);
        soft_rst_req = 1'b0;
        expect_release("soft_hold", HC);

        // Glitch during STABLE restarts the whole window.
        rst_n = 1'b0;
        cyc(1);
        rst_n      = 1'b1;
        pll_locked = 1'b1;
        cyc(5);
        chk("glitch_stable_rst", 32'(cpu_rst), 32'd1);
        pll_locked = 1'b0;
        cyc(3);
        chk("glitch_low_rst", 32'(cpu_rst), 32'd1);
        pll_locked = 1'b1;
        expect_release("glitch", RELEASE_EDGES);
        chk("glitch_lock_lost", 32'(lock_lost), 32'd0);

        // Repeated lock loss from RUN; third loss coincides with a soft request.
        for (int k = 1; k <= 5; k++) begin
            pll_locked = 1'b0;
            cyc(SYNC_STAGES);
            chk("loss_still_run", 32'(cpu_rst), 32'd0);
            if (k == 3) soft_rst_req = 1'b1;
            else        soft_rst_req = 1'b0;
            cyc(1);
            soft_rst_req = 1'b0;
            exp_loss = LC_EN ? ((k < 3) ? k : 3) : 0;
            chk("loss_cpu_rst", 32'(cpu_rst), 32'd1);
            chk("loss_ready", 32'(ready), 32'd0);
            chk("loss_lock_lost", 32'(lock_lost), 32'd1);
            chk("loss_count", 32'(loss_count), 32'(exp_loss));
            pll_locked = 1'b1;
            expect_release("loss_relock", RELEASE_EDGES);
        end

        // Async reset between edges while in HOLD.
        soft_rst_req = 1'b1;
        cyc(1);
        soft_rst_req = 1'b0;
        chk("hold_entry", 32'(cpu_rst), 32'd1);
        cyc(1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_hold_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("arst_hold_ready", 32'(ready), 32'd0);
        chk("arst_hold_lock_lost", 32'(lock_lost), 32'd0);
        chk("arst_hold_loss_count", 32'(loss_count), 32'd0);
        cyc(2);
        rst_n = 1'b1;
        expect_release("arst_restart", RELEASE_EDGES);

        // Async reset between edges while in RUN.
        #2 rst_n = 1'b0;
        #1;
        chk("arst_run_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("arst_run_ready", 32'(ready), 32'd0);
        cyc(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
